// File: rtl/gateway_recv_mc_if.sv
// Per-lane AXI-Stream bundle for the P2P receive gateway; lane k occupies slice k of each vector.
// Handshake: a beat transfers on a rising clock edge where tvalid and tready are both 1; the master
// holds tvalid and payload stable until then, and tready may depend combinationally on the far side.
interface gateway_recv_mc_if #(
  parameter int N_CH      = 2,
  parameter int DATA_BITS = 512,
  parameter int DEST_BITS = 14
);
  logic [N_CH-1:0]             tvalid;
  logic [N_CH-1:0]             tready;
  logic [N_CH-1:0]             tlast;
  logic [N_CH*DATA_BITS-1:0]   tdata;
  logic [N_CH*DATA_BITS/8-1:0] tkeep;
  logic [N_CH*DEST_BITS-1:0]   tdest;

  modport master (output tvalid, tlast, tdata, tkeep, tdest, input tready);
  modport slave  (input tvalid, tlast, tdata, tkeep, tdest, output tready);
endinterface

// File: rtl/gateway_recv_mc.sv
// Multi-lane P2P receive gateway: per-packet sender admission against allow_mask,
// zero-latency forwarding of admitted packets, silent discard of the rest, with counters and violation reports.
module gateway_recv_mc #(
  parameter int N_CH      = 2,
  parameter int N_REGIONS = 2,
  parameter int DATA_BITS = 512,
  parameter int DEST_BITS = 14,
  parameter int CNT_BITS  = 32
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [N_REGIONS-1:0]                   allow_mask,
  input  logic                                   gate_en,
  input  logic                                   cnt_clr,
  gateway_recv_mc_if.slave                       s_axis,
  gateway_recv_mc_if.master                      m_axis,
  output logic [N_CH*4-1:0]                      m_tid,
  output logic [N_CH*CNT_BITS-1:0]               pass_cnt,
  output logic [N_CH*CNT_BITS-1:0]               drop_cnt,
  output logic                                   viol_valid,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] viol_ch,
  output logic [3:0]                             viol_sender,
  output logic [N_CH-1:0]                        viol_sticky,
  output logic [2*N_CH-1:0]                      dbg_state
);

  localparam int CH_BITS   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t              state_q [N_CH];
  state_t              state_d [N_CH];
  logic [3:0]          tid_q   [N_CH];
  logic [CNT_BITS-1:0] pass_q  [N_CH];
  logic [CNT_BITS-1:0] drop_q  [N_CH];

  logic [3:0]          sender  [N_CH];
  logic [15:0]         mask_ext;
  logic [N_CH-1:0]     allowed, fwd, rdy, hs, first, viol, pass_inc, drop_inc;
  logic [CH_BITS-1:0]  vch;
  logic [3:0]          vsnd;

  // Payload is a pure wire path; only valid/ready are steered by the lane decision.
  for (genvar g = 0; g < N_CH; g++) begin : g_lane_payload
    assign m_axis.tdata[g*DATA_BITS +: DATA_BITS] = s_axis.tdata[g*DATA_BITS +: DATA_BITS];
    assign m_axis.tkeep[g*KEEP_BITS +: KEEP_BITS] = s_axis.tkeep[g*KEEP_BITS +: KEEP_BITS];
    assign m_axis.tdest[g*DEST_BITS +: DEST_BITS] = s_axis.tdest[g*DEST_BITS +: DEST_BITS];
    assign m_axis.tlast[g]                        = s_axis.tlast[g];
  end

  always_comb begin
    mask_ext                  = '0;
    mask_ext[N_REGIONS-1:0]   = allow_mask;
    allowed                   = '0;
    fwd                       = '0;
    rdy                       = '0;
    hs                        = '0;
    first                     = '0;
    viol                      = '0;
    pass_inc                  = '0;
    drop_inc                  = '0;
    m_axis.tvalid             = '0;
    m_tid                     = '0;
    dbg_state                 = '0;
    for (int k = 0; k < N_CH; k++) begin
      sender[k]  = s_axis.tdest[k*DEST_BITS+6 +: 4];
      // Sender IDs beyond N_REGIONS hit the zero padding of mask_ext and are refused.
      allowed[k] = !gate_en || mask_ext[sender[k]];
      // Mid-packet the decision comes only from the state, so mask/gate changes cannot reach it.
      fwd[k]     = (state_q[k] == ST_PASS) || ((state_q[k] == ST_IDLE) && allowed[k]);
      rdy[k]     = !areset && (fwd[k] ? m_axis.tready[k] : 1'b1);
      m_axis.tvalid[k] = !areset && s_axis.tvalid[k] && fwd[k];
      hs[k]       = s_axis.tvalid[k] && rdy[k];
      first[k]    = (state_q[k] == ST_IDLE) && hs[k];
      viol[k]     = first[k] && !fwd[k];
      pass_inc[k] = hs[k] && s_axis.tlast[k] && fwd[k];
      drop_inc[k] = hs[k] && s_axis.tlast[k] && !fwd[k];
      m_tid[k*4 +: 4]     = (state_q[k] == ST_IDLE) ? sender[k] : tid_q[k];
      dbg_state[2*k +: 2] = state_q[k];

      state_d[k] = state_q[k];
      case (state_q[k])
        ST_IDLE: if (hs[k] && !s_axis.tlast[k]) state_d[k] = fwd[k] ? ST_PASS : ST_DROP;
        ST_PASS,
        ST_DROP: if (hs[k] && s_axis.tlast[k]) state_d[k] = ST_IDLE;
        default: state_d[k] = ST_IDLE;
      endcase
    end
    s_axis.tready = rdy;

    // Lowest violating lane wins the single report slot.
    vch  = '0;
    vsnd = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (viol[k]) begin
        vch  = CH_BITS'(k);
        vsnd = sender[k];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < N_CH; k++) state_q[k] <= ST_IDLE;
    end else begin
      for (int k = 0; k < N_CH; k++) state_q[k] <= state_d[k];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < N_CH; k++) begin
        tid_q[k]  <= '0;
        pass_q[k] <= '0;
        drop_q[k] <= '0;
      end
      viol_sticky <= '0;
      viol_valid  <= 1'b0;
      viol_ch     <= '0;
      viol_sender <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (first[k]) tid_q[k] <= sender[k];
        if (cnt_clr) begin
          pass_q[k]      <= '0;
          drop_q[k]      <= '0;
          viol_sticky[k] <= 1'b0;
        end else begin
          if (pass_inc[k] && (pass_q[k] != '1)) pass_q[k] <= pass_q[k] + CNT_ONE;
          if (drop_inc[k] && (drop_q[k] != '1)) drop_q[k] <= drop_q[k] + CNT_ONE;
          if (viol[k]) viol_sticky[k] <= 1'b1;
        end
      end
      viol_valid <= |viol;
      if (|viol) begin
        viol_ch     <= vch;
        viol_sender <= vsnd;
      end
    end
  end

  always_comb begin
    pass_cnt = '0;
    drop_cnt = '0;
    for (int k = 0; k < N_CH; k++) begin
      pass_cnt[k*CNT_BITS +: CNT_BITS] = pass_q[k];
      drop_cnt[k*CNT_BITS +: CNT_BITS] = drop_q[k];
    end
  end

endmodule

// File: tb/tb_gateway_recv_mc.sv
// Directed bench for gateway_recv_mc: drivers push expected beats/violations into queues,
// a negedge monitor pops and compares whatever the DUT emits.
module tb_gateway_recv_mc;

  localparam int N_CH = 2;
  localparam int N_REGIONS = 2;
  localparam int DATA_BITS = 32;
  localparam int DEST_BITS = 14;
  localparam int CNT_BITS = 4;
  localparam int IW = 4 + 14 + 1 + 4 + 32;

  logic aclk;
  logic areset;
  logic [N_REGIONS-1:0] allow_mask;
  logic gate_en;
  logic cnt_clr;
  logic [N_CH*4-1:0] m_tid;
  logic [N_CH*CNT_BITS-1:0] pass_cnt;
  logic [N_CH*CNT_BITS-1:0] drop_cnt;
  logic viol_valid;
  logic [0:0] viol_ch;
  logic [3:0] viol_sender;
  logic [N_CH-1:0] viol_sticky;
  logic [2*N_CH-1:0] dbg_state;

  gateway_recv_mc_if #(.N_CH(N_CH), .DATA_BITS(DATA_BITS), .DEST_BITS(DEST_BITS)) s_bus ();
  gateway_recv_mc_if #(.N_CH(N_CH), .DATA_BITS(DATA_BITS), .DEST_BITS(DEST_BITS)) m_bus ();

  gateway_recv_mc #(
    .N_CH(N_CH), .N_REGIONS(N_REGIONS), .DATA_BITS(DATA_BITS),
    .DEST_BITS(DEST_BITS), .CNT_BITS(CNT_BITS)
  ) dut (
    .aclk(aclk), .areset(areset), .allow_mask(allow_mask), .gate_en(gate_en),
    .cnt_clr(cnt_clr), .s_axis(s_bus.slave), .m_axis(m_bus.master), .m_tid(m_tid),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt), .viol_valid(viol_valid), .viol_ch(viol_ch),
    .viol_sender(viol_sender), .viol_sticky(viol_sticky), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- per-lane drive variables ----------------
  logic        drv_valid [N_CH];
  logic        drv_last  [N_CH];
  logic        drv_mready[N_CH];
  logic [31:0] drv_data  [N_CH];
  logic [3:0]  drv_keep  [N_CH];
  logic [13:0] drv_dest  [N_CH];

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      s_bus.tvalid[k]         = drv_valid[k];
      s_bus.tlast[k]          = drv_last[k];
      s_bus.tdata[k*32 +: 32] = drv_data[k];
      s_bus.tkeep[k*4 +: 4]   = drv_keep[k];
      s_bus.tdest[k*14 +: 14] = drv_dest[k];
      m_bus.tready[k]         = drv_mready[k];
    end
  end

  // ---------------- scoreboard ----------------
  logic [IW-1:0] exp_q [N_CH][$];
  logic [4:0]    exp_viol_q[$];
  int tests = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [IW-1:0] got;
    logic [IW-1:0] want;
    logic [4:0]    vgot;
    logic [4:0]    vwant;
    forever begin
      @(negedge aclk);
      for (int k = 0; k < N_CH; k++) begin
        if (m_bus.tvalid[k] && m_bus.tready[k]) begin
          got = {m_tid[k*4 +: 4], m_bus.tdest[k*14 +: 14], m_bus.tlast[k],
                 m_bus.tkeep[k*4 +: 4], m_bus.tdata[k*32 +: 32]};
          tests++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL beat_lane%0d: got %h expected no beat", k, got);
          end else begin
            want = exp_q[k].pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL beat_lane%0d: got %h expected %h", k, got, want);
            end
          end
        end
      end
      if (viol_valid) begin
        vgot = {viol_ch, viol_sender};
        tests++;
        if (exp_viol_q.size() == 0) begin
          errors++;
          $display("FAIL viol_report: got ch/sender %h expected no report", vgot);
        end else begin
          vwant = exp_viol_q.pop_front();
          if (vgot !== vwant) begin
            errors++;
            $display("FAIL viol_report: got ch/sender %h expected %h", vgot, vwant);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_pkt(input int ln, input logic [3:0] snd, input int nb,
                          input bit pass, input logic [7:0] tag);
    logic [31:0] d;
    logic [13:0] dst;
    logic [3:0]  kp;
    int guard;
    for (int b = 0; b < nb; b++) begin
      d   = {8'hA5, tag, 8'(ln), 8'(b)};
      dst = {4'(ln + 1), snd, 6'(b)};
      kp  = 4'(b + 1);
      drv_valid[ln] = 1'b1;
      drv_last[ln]  = (b == nb - 1);
      drv_data[ln]  = d;
      drv_dest[ln]  = dst;
      drv_keep[ln]  = kp;
      if (pass) exp_q[ln].push_back({snd, dst, drv_last[ln], kp, d});
      @(negedge aclk);
      if (!pass) begin
        check($sformatf("drop_ready_l%0d", ln), 32'(s_bus.tready[ln]), 32'd1);
        check($sformatf("drop_mvalid_l%0d", ln), 32'(m_bus.tvalid[ln]), 32'd0);
      end
      guard = 0;
      while (!s_bus.tready[ln] && guard < 100) begin
        @(negedge aclk);
        guard++;
      end
      if (guard >= 100) check($sformatf("hs_timeout_l%0d", ln), 32'(guard), 32'd0);
      @(posedge aclk);
      #1;
    end
    drv_valid[ln] = 1'b0;
    drv_last[ln]  = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    areset = 1'b1;
    allow_mask = 2'b10;
    gate_en = 1'b1;
    cnt_clr = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      drv_valid[k] = 1'b0; drv_last[k] = 1'b0; drv_mready[k] = 1'b1;
      drv_data[k] = '0; drv_keep[k] = '0; drv_dest[k] = '0;
    end

    // reset state
    repeat (2) @(negedge aclk);
    check("rst_s_tready", 32'(s_bus.tready), 32'd0);
    check("rst_m_tvalid", 32'(m_bus.tvalid), 32'd0);
    check("rst_pass_cnt", 32'(pass_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_viol", 32'({viol_valid, viol_ch, viol_sender, viol_sticky}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge aclk); #1 areset = 1'b0;
    @(posedge aclk); #1;

    // allowed 4-beat packet, sender 1 on lane 0
    send_pkt(0, 4'd1, 4, 1'b1, 8'h34);
    settle();
    check("t34_pass_cnt0", 32'(pass_cnt[3:0]), 32'd1);
    check("t34_sticky", 32'(viol_sticky), 32'd0);

    // disallowed 3-beat packet, sender 0 on lane 1
    @(posedge aclk); #1;
    exp_viol_q.push_back({1'b1, 4'd0});
    send_pkt(1, 4'd0, 3, 1'b0, 8'h35);
    settle();
    check("t35_drop_cnt1", 32'(drop_cnt[7:4]), 32'd1);
    check("t35_sticky", 32'(viol_sticky), 32'b10);

    // backpressure toggling with allow_mask withdrawn mid-packet
    @(posedge aclk); #1;
    fork
      send_pkt(0, 4'd1, 5, 1'b1, 8'h36);
      begin : mask_drop
        int g;
        g = 0;
        @(negedge aclk);
        while (!(m_bus.tvalid[0] && m_bus.tready[0]) && g < 50) begin
          @(negedge aclk);
          g++;
        end
        @(posedge aclk); #1 allow_mask = 2'b00;
      end
      begin : toggle
        for (int c = 0; c < 20; c++) begin
          drv_mready[0] = c[0];
          @(posedge aclk); #1;
        end
        drv_mready[0] = 1'b1;
      end
    join
    settle();
    check("t36_pass_cnt0", 32'(pass_cnt[3:0]), 32'd2);
    check("t36_drop_cnt0", 32'(drop_cnt[3:0]), 32'd0);

    // clear counters and sticky
    @(posedge aclk); #1 cnt_clr = 1'b1;
    @(posedge aclk); #1 cnt_clr = 1'b0;
    @(negedge aclk);
    check("clr_pass", 32'(pass_cnt), 32'd0);
    check("clr_sticky", 32'(viol_sticky), 32'd0);

    // both lanes violate in the same cycle; lane 0 reported
    @(posedge aclk); #1;
    exp_viol_q.push_back({1'b0, 4'd0});
    fork
      send_pkt(0, 4'd0, 2, 1'b0, 8'h37);
      send_pkt(1, 4'd1, 2, 1'b0, 8'h37);
    join
    settle();
    check("t37_drop_cnt0", 32'(drop_cnt[3:0]), 32'd1);
    check("t37_drop_cnt1", 32'(drop_cnt[7:4]), 32'd1);
    check("t37_sticky", 32'(viol_sticky), 32'b11);

    // out-of-range sender refused even with full mask; passes with gate off
    allow_mask = 2'b11;
    @(posedge aclk); #1;
    exp_viol_q.push_back({1'b1, 4'd2});
    send_pkt(1, 4'd2, 1, 1'b0, 8'h40);
    settle();
    check("range_drop_cnt1", 32'(drop_cnt[7:4]), 32'd2);
    gate_en = 1'b0;
    allow_mask = 2'b00;
    @(posedge aclk); #1;
    send_pkt(1, 4'd2, 1, 1'b1, 8'h41);
    settle();
    check("gateoff_pass_cnt1", 32'(pass_cnt[7:4]), 32'd1);

    // saturation on a 4-bit counter
    gate_en = 1'b1;
    allow_mask = 2'b11;
    @(posedge aclk); #1;
    for (int i = 0; i < 15; i++) send_pkt(0, 4'd0, 1, 1'b1, 8'(8'h50 + i));
    settle();
    check("sat_pass_cnt0_f", 32'(pass_cnt[3:0]), 32'hF);
    @(posedge aclk); #1;
    send_pkt(0, 4'd0, 1, 1'b1, 8'h60);
    settle();
    check("sat_pass_cnt0_hold", 32'(pass_cnt[3:0]), 32'hF);

    // clear coincident with a forwarded tlast handshake
    @(posedge aclk); #1;
    fork
      send_pkt(0, 4'd1, 1, 1'b1, 8'h61);
      begin
        cnt_clr = 1'b1;
        @(posedge aclk); #1 cnt_clr = 1'b0;
      end
    join
    settle();
    check("clr_wins_pass_cnt0", 32'(pass_cnt[3:0]), 32'd0);

    // reset during beat 2 of a dropped packet
    allow_mask = 2'b01;
    @(posedge aclk); #1;
    exp_viol_q.push_back({1'b1, 4'd1});
    drv_valid[1] = 1'b1; drv_last[1] = 1'b0;
    drv_data[1] = 32'hDEAD0001; drv_dest[1] = {4'd2, 4'd1, 6'd0}; drv_keep[1] = 4'hF;
    @(posedge aclk); #1;
    drv_data[1] = 32'hDEAD0002; drv_dest[1] = {4'd2, 4'd1, 6'd1};
    @(negedge aclk);
    check("t39_in_drop", 32'(dbg_state[3:2]), 32'd2);
    #1 areset = 1'b1;
    #1;
    check("t39_s_tready", 32'(s_bus.tready), 32'd0);
    check("t39_m_tvalid", 32'(m_bus.tvalid), 32'd0);
    check("t39_drop_cnt", 32'(drop_cnt), 32'd0);
    check("t39_viol", 32'({viol_valid, viol_ch, viol_sender, viol_sticky}), 32'd0);
    check("t39_state", 32'(dbg_state), 32'd0);
    @(posedge aclk); #1 drv_valid[1] = 1'b0;
    #2 areset = 1'b0;
    @(posedge aclk); #1;
    send_pkt(1, 4'd0, 1, 1'b1, 8'h39);
    settle();
    check("t39_pass_cnt1", 32'(pass_cnt[7:4]), 32'd1);
    check("t39_pass_cnt0", 32'(pass_cnt[3:0]), 32'd0);
    check("t39_drop_after", 32'(drop_cnt), 32'd0);

    // nothing expected may be left outstanding
    repeat (2) @(negedge aclk);
    check("residual_lane0", 32'(exp_q[0].size()), 32'd0);
    check("residual_lane1", 32'(exp_q[1].size()), 32'd0);
    check("residual_viol", 32'(exp_viol_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/gateway_recv_mc.md
GATEWAY_RECV_MC -- requirements
Module: gateway_recv_mc

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent P2P receive lanes.
REQ-002 SHALL have parameter N_REGIONS, default 2: number of vFPGA regions; valid sender IDs are 0..N_REGIONS-1.
REQ-003 SHALL have parameter DATA_BITS, default 512: tdata width per lane; tkeep is DATA_BITS/8.
REQ-004 SHALL have parameter DEST_BITS, default 14: tdest width; sender ID is tdest[9:6] (4 bits).
REQ-005 SHALL have parameter CNT_BITS, default 32: per-lane packet counter width.
REQ-006 aclk  in  1  sole clock; all state on rising edge.
REQ-007 areset  in  1  asynchronous, active-high reset.
REQ-008 allow_mask  in  N_REGIONS  bit i=1 permits packets from sender i on all lanes.
REQ-009 gate_en  in  1  0 = pass every packet unchecked; 1 = enforce allow_mask.
REQ-010 cnt_clr  in  1  synchronous clear of all counters and sticky flags.
REQ-011 s_tvalid/s_tready/s_tlast  in/out/in  N_CH each  per-lane slave handshake.
REQ-012 s_tdata/s_tkeep/s_tdest  in  N_CH*DATA_BITS / N_CH*DATA_BITS/8 / N_CH*DEST_BITS  flattened slave payload, lane k at slice k.
REQ-013 m_tvalid/m_tready/m_tlast  out/in/out  N_CH each  per-lane master handshake.
REQ-014 m_tdata/m_tkeep/m_tdest/m_tid  out  matching widths, m_tid N_CH*4  master payload; m_tid = latched sender ID.
REQ-015 pass_cnt/drop_cnt  out  N_CH*CNT_BITS each  per-lane forwarded and dropped packet counts.
REQ-016 viol_valid/viol_ch/viol_sender  out  1 / clog2(N_CH) (min 1) / 4  one-cycle violation report.
REQ-017 viol_sticky  out  N_CH  per-lane sticky violation flag.

Function
REQ-018 Each lane SHALL run an independent FSM with states IDLE, PASS and DROP.
REQ-019 In IDLE, a lane SHALL decide on the first beat (s_tvalid=1): allowed = !gate_en or (sender<N_REGIONS and allow_mask[sender]).
REQ-020 Allowed first beat: m_tvalid=s_tvalid, s_tready=m_tready, payload combinational pass-through with zero added latency; on handshake without tlast go to PASS, with tlast stay in IDLE.
REQ-021 Disallowed first beat: m_tvalid=0, s_tready=1, beat consumed and discarded; without tlast go to DROP, with tlast stay in IDLE.
REQ-022 PASS SHALL forward beats as in REQ-020 and return to IDLE on the handshake of the tlast beat.
REQ-023 DROP SHALL hold s_tready=1 and m_tvalid=0, discarding beats, and return to IDLE on the tlast beat.
REQ-024 Decision, sender ID and m_tid SHALL be latched at the first beat and held for the whole packet; allow_mask and gate_en changes mid-packet SHALL NOT affect that packet.
REQ-025 m_tdest SHALL equal s_tdest of the current beat.
REQ-026 pass_cnt SHALL increment by 1 on handshake of each forwarded tlast beat; drop_cnt SHALL increment by 1 on each consumed dropped tlast beat.
REQ-027 Counters SHALL saturate at all-ones, not wrap.
REQ-028 cnt_clr SHALL zero all counters and viol_sticky next cycle; clear SHALL win over a same-cycle increment or violation.
REQ-029 On each disallowed first beat, viol_valid SHALL pulse high the next cycle with that lane index and sender ID, and viol_sticky[lane] SHALL set.
REQ-030 If several lanes violate in the same cycle, the lowest lane index SHALL be reported; all such lanes SHALL still set viol_sticky and count drops.
REQ-031 Lanes SHALL NOT stall each other; a dropping lane SHALL never block its upstream.

Reset
REQ-032 While areset=1: all FSMs IDLE, counters 0, viol_valid 0, viol_sticky 0, viol_ch 0, viol_sender 0, m_tvalid 0, s_tready 0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet; after release the next beat on that lane SHALL be treated as a first beat.

Verification
REQ-034 gate_en=1, allow_mask=2'b10, lane 0 sends 4-beat packet sender 1 -> 4 beats out, m_tid=1, pass_cnt[0]=1, no viol_valid.
REQ-035 Same config, lane 1 sends 3-beat packet sender 0 -> m_tvalid stays 0, s_tready=1 for 3 cycles, drop_cnt[1]=1, viol_valid one cycle with viol_ch=1, viol_sender=0, viol_sticky=2'b10.
REQ-036 Lane 0 allowed packet with m_tready toggling 1/0 each cycle, allow_mask cleared after beat 1 -> all beats delivered in order, no data loss, pass_cnt[0]=1.
REQ-037 Both lanes violate on the same cycle (senders 0 and 1, mask 0) -> viol_ch=0, viol_sender from lane 0, viol_sticky=2'b11, drop_cnt=1 on both lanes.
REQ-038 Preload pass_cnt[0] to all-ones via 2^CNT_BITS-1 packets (CNT_BITS=4 build) -> one more packet leaves 4'hF; cnt_clr coincident with a tlast -> counter reads 0.
REQ-039 areset pulsed during beat 2 of a DROP packet -> outputs take REQ-032 values; after release an allowed single-beat packet passes and pass_cnt=1.
